tt_um_jleugeri_ttt_spike_router: RTL and testbench

TT_UM_JLEUGERI_TTT_SPIKE_ROUTER -- requirements
Module: tt_um_jleugeri_ttt_spike_router

---
 rtl/tt_um_jleugeri_ttt_spike_router.sv | 167 ++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_spike_router.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_jleugeri_ttt_spike_router.sv
// Spike router: queues firing sources and streams each source's CSR fan-out
// (target, good/bad token weights) over a valid/ready port. Memories are programmed while idle.
module tt_um_jleugeri_ttt_spike_router #(
  parameter int NUM_PROCESSORS  = 4,
  parameter int NUM_CONNECTIONS = NUM_PROCESSORS * NUM_PROCESSORS,
  parameter int NEW_TOKEN_BITS  = 4,
  parameter int QUEUE_DEPTH     = 4,
  localparam int PW  = $clog2(NUM_PROCESSORS),
  localparam int PIW = $clog2(NUM_PROCESSORS + 1),
  localparam int CW  = $clog2(NUM_CONNECTIONS + 1),
  localparam int T   = NEW_TOKEN_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [PW-1:0]       src_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PW-1:0]       target_id,
  output logic signed [T-1:0] new_good_tokens,
  output logic signed [T-1:0] new_bad_tokens,
  output logic [PW-1:0]       out_src_id,
  output logic                out_last,
  input  logic                prog_en,
  input  logic [1:0]          prog_op,
  input  logic [CW-1:0]       prog_addr,
  input  logic [PIW-1:0]      prog_index,
  input  logic signed [T-1:0] prog_tokens,
  output logic                prog_ack,
  output logic                prog_err,
  output logic                range_err,
  output logic                busy
);

  localparam int AW = (NUM_CONNECTIONS > 1) ? $clog2(NUM_CONNECTIONS) : 1;
  localparam int QW = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
  state_t state;

  logic [CW-1:0]       indptr   [NUM_PROCESSORS+1];
  logic [PW-1:0]       indices  [NUM_CONNECTIONS];
  logic signed [T-1:0] good_mem [NUM_CONNECTIONS];
  logic signed [T-1:0] bad_mem  [NUM_CONNECTIONS];

  logic [PW-1:0] fifo_mem [QUEUE_DEPTH];
  logic [QW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;

  logic [PW-1:0] cur_id;
  logic [CW-1:0] addr, stop_addr, next_addr, fetch_start, fetch_stop;
  logic [AW-1:0] rd_idx;
  logic          prog_in_range, prog_accept, fetch_bad;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[QW] != rd_ptr[QW]) && (wr_ptr[QW-1:0] == rd_ptr[QW-1:0]);
  assign src_ready  = !fifo_full;
  assign push       = src_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign busy       = (state != IDLE) || !fifo_empty;

  assign fetch_start = indptr[PIW'(cur_id)];
  assign fetch_stop  = indptr[PIW'(cur_id) + PIW'(1)];
  assign fetch_bad   = (fetch_start > fetch_stop) || (fetch_stop > CW'(NUM_CONNECTIONS));
  assign next_addr   = addr + CW'(1);

  always_comb begin
    rd_idx = next_addr[AW-1:0];
    if (state == FETCH) rd_idx = fetch_start[AW-1:0];
  end

  always_comb begin
    prog_in_range = 1'b0;
    case (prog_op)
      2'b00, 2'b01: prog_in_range = (prog_addr < CW'(NUM_CONNECTIONS));
      2'b10: prog_in_range = (prog_index <= PIW'(NUM_PROCESSORS)) &&
                             (prog_addr <= CW'(NUM_CONNECTIONS));
      default: prog_in_range = (prog_addr < CW'(NUM_CONNECTIONS)) &&
                               (prog_index < PIW'(NUM_PROCESSORS));
    endcase
  end

  assign prog_accept = prog_en && !busy && prog_in_range;

  // Connection and queue storage: not reset, contents survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_accept) begin
      case (prog_op)
        2'b00:   good_mem[prog_addr[AW-1:0]] <= prog_tokens;
        2'b01:   bad_mem[prog_addr[AW-1:0]]  <= prog_tokens;
        2'b10:   indptr[prog_index]          <= prog_addr;
        default: indices[prog_addr[AW-1:0]]  <= prog_index[PW-1:0];
      endcase
    end
    if (push) fifo_mem[wr_ptr[QW-1:0]] <= src_id;
  end

  always_ff @(posedge clk) begin
    if (pop) cur_id <= fifo_mem[rd_ptr[QW-1:0]];
    if (state == FETCH) begin
      addr      <= fetch_start;
      stop_addr <= fetch_stop;
    end else if (state == STREAM && out_ready) begin
      addr <= next_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      target_id       <= '0;
      out_src_id      <= '0;
      new_good_tokens <= '0;
      new_bad_tokens  <= '0;
      prog_ack        <= 1'b0;
      prog_err        <= 1'b0;
      range_err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (QW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (QW+1)'(1);
      prog_ack <= prog_accept;
      prog_err <= prog_en && !prog_accept;
      case (state)
        IDLE: if (pop) state <= FETCH;
        FETCH: begin
          if (fetch_bad) begin
            range_err <= 1'b1;
            state     <= IDLE;
          end else if (fetch_start == fetch_stop) begin
            state <= IDLE;
          end else begin
            state           <= STREAM;
            out_valid       <= 1'b1;
            out_src_id      <= cur_id;
            target_id       <= indices[rd_idx];
            new_good_tokens <= good_mem[rd_idx];
            new_bad_tokens  <= bad_mem[rd_idx];
            out_last        <= (fetch_start + CW'(1) == fetch_stop);
          end
        end
        STREAM: begin
          // Outputs only advance on a completed handshake, so they hold under back-pressure.
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              target_id       <= indices[rd_idx];
              new_good_tokens <= good_mem[rd_idx];
              new_bad_tokens  <= bad_mem[rd_idx];
              out_last        <= (next_addr + CW'(1) == stop_addr);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_spike_router.sv
// Directed bench for the spike router: programs a small CSR table and checks
// streaming, back-pressure, FIFO limits, programming errors, range errors and reset.
module tb_tt_um_jleugeri_ttt_spike_router;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              src_valid, src_ready;
  logic [1:0]        src_id;
  logic              out_valid, out_ready;
  logic [1:0]        target_id, out_src_id;
  logic signed [3:0] new_good_tokens, new_bad_tokens;
  logic              out_last;
  logic              prog_en;
  logic [1:0]        prog_op;
  logic [4:0]        prog_addr;
  logic [2:0]        prog_index;
  logic signed [3:0] prog_tokens;
  logic              prog_ack, prog_err, range_err, busy;

  int checks = 0;
  int failures = 0;

  tt_um_jleugeri_ttt_spike_router dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_id(src_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .target_id(target_id), .new_good_tokens(new_good_tokens),
    .new_bad_tokens(new_bad_tokens), .out_src_id(out_src_id), .out_last(out_last),
    .prog_en(prog_en), .prog_op(prog_op), .prog_addr(prog_addr),
    .prog_index(prog_index), .prog_tokens(prog_tokens),
    .prog_ack(prog_ack), .prog_err(prog_err), .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [1:0] op, input int addr, input int idx,
                      input int tok, input logic ok);
    prog_en     = 1'b1;
    prog_op     = op;
    prog_addr   = 5'(addr);
    prog_index  = 3'(idx);
    prog_tokens = 4'(tok);
    tick();
    prog_en = 1'b0;
    check("prog_ack", prog_ack, ok);
    check("prog_err", prog_err, !ok);
  endtask

  task automatic enqueue(input int id);
    src_id    = 2'(id);
    src_valid = 1'b1;
    check("src_ready_enq", src_ready, 1);
    tick();
    src_valid = 1'b0;
  endtask

  // Waits (bounded) for an entry with out_ready=1, checks it, then consumes it.
  task automatic expect_entry(input int tgt, input int g, input int b,
                              input int last, input int src);
    int n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("entry_valid", out_valid, 1);
    check("entry_target", target_id, tgt);
    check("entry_good", new_good_tokens, g);
    check("entry_bad", new_bad_tokens, b);
    check("entry_last", out_last, last);
    check("entry_src", out_src_id, src);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid = 1'b0; src_id = '0; out_ready = 1'b0;
    prog_en = 1'b0; prog_op = '0; prog_addr = '0; prog_index = '0; prog_tokens = '0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_src_ready", src_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_prog_ack", prog_ack, 0);
    check("rst_prog_err", prog_err, 0);
    check("rst_range_err", range_err, 0);
    check("rst_target", target_id, 0);
    check("rst_src", out_src_id, 0);
    check("rst_good", new_good_tokens, 0);
    check("rst_bad", new_bad_tokens, 0);
    rst_n = 1'b1;
    tick();

    // indptr = {0,2,2,3,3}; P0 -> (1,+3,-1),(2,-8,+7); P2 -> (3,1,0)
    prog(2'b10, 0, 0, 0, 1'b1);
    prog(2'b10, 2, 1, 0, 1'b1);
    prog(2'b10, 2, 2, 0, 1'b1);
    prog(2'b10, 3, 3, 0, 1'b1);
    prog(2'b10, 3, 4, 0, 1'b1);
    prog(2'b11, 0, 1, 0, 1'b1);
    prog(2'b00, 0, 0, 3, 1'b1);
    prog(2'b01, 0, 0, -1, 1'b1);
    prog(2'b11, 1, 2, 0, 1'b1);
    prog(2'b00, 1, 0, -8, 1'b1);
    prog(2'b01, 1, 0, 7, 1'b1);
    prog(2'b11, 2, 3, 0, 1'b1);
    prog(2'b00, 2, 0, 1, 1'b1);
    prog(2'b01, 2, 0, 0, 1'b1);
    tick();
    check("ack_pulse_end", prog_ack, 0);

    // Basic fan-out with exact latency n+3
    out_ready = 1'b1;
    enqueue(0);
    check("lat_n1_valid", out_valid, 0);
    check("lat_n1_busy", busy, 1);
    tick();
    check("lat_n2_valid", out_valid, 0);
    tick();
    check("lat_n3_valid", out_valid, 1);
    check("e0_target", target_id, 1);
    check("e0_good", new_good_tokens, 3);
    check("e0_bad", new_bad_tokens, -1);
    check("e0_last", out_last, 0);
    check("e0_src", out_src_id, 0);
    tick();
    check("e1_valid", out_valid, 1);
    check("e1_target", target_id, 2);
    check("e1_good", new_good_tokens, -8);
    check("e1_bad", new_bad_tokens, 7);
    check("e1_last", out_last, 1);
    tick();
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 0);

    // Empty fan-out
    enqueue(1);
    check("empty_busy1", busy, 1);
    tick();
    check("empty_valid2", out_valid, 0);
    tick();
    check("empty_valid3", out_valid, 0);
    check("empty_busy3", busy, 0);
    check("empty_range_err", range_err, 0);

    // Back-to-back enqueue under back-pressure: first pops, four more fill the FIFO
    out_ready = 1'b0;
    src_valid = 1'b1;
    src_id = 2'd0; tick();
    src_id = 2'd2; tick();
    src_id = 2'd0; tick();
    src_id = 2'd2; tick();
    src_id = 2'd0;
    check("fifo_ready_before_5th", src_ready, 1);
    tick();
    check("fifo_full_ready", src_ready, 0);
    src_id = 2'd2;
    tick();
    src_valid = 1'b0;
    check("fifo_full_ready2", src_ready, 0);
    check("hold_valid", out_valid, 1);
    check("hold_target", target_id, 1);
    check("hold_good", new_good_tokens, 3);
    tick();
    tick();
    check("hold_valid2", out_valid, 1);
    check("hold_target2", target_id, 1);
    check("hold_bad2", new_bad_tokens, -1);
    check("hold_last2", out_last, 0);
    out_ready = 1'b1;
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);
    expect_entry(3, 1, 0, 1, 2);
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);
    expect_entry(3, 1, 0, 1, 2);
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);
    check("drop_valid", out_valid, 0);
    check("drop_busy", busy, 0);

    // Programming while streaming, and out-of-range programming
    out_ready = 1'b0;
    enqueue(0);
    tick();
    tick();
    check("pb_stream_valid", out_valid, 1);
    prog(2'b00, 0, 0, 5, 1'b0);
    tick();
    check("pb_err_pulse_end", prog_err, 0);
    out_ready = 1'b1;
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);
    prog(2'b00, 16, 0, 5, 1'b0);
    prog(2'b11, 0, 4, 0, 1'b0);
    prog(2'b10, 17, 0, 0, 1'b0);
    tick();
    check("range_prog_err_end", prog_err, 0);
    enqueue(0);
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);

    // Reset in the middle of a stream with a queued source
    out_ready = 1'b0;
    enqueue(0);
    enqueue(2);
    tick();
    check("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_src_ready", src_ready, 1);
    check("arst_target", target_id, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    out_ready = 1'b1;
    enqueue(0);
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);
    check("post_rst_done_busy", busy, 0);

    // Inverted indptr range for P3
    prog(2'b10, 3, 3, 0, 1'b1);
    prog(2'b10, 1, 4, 0, 1'b1);
    enqueue(3);
    tick();
    check("rerr_fetch", range_err, 0);
    tick();
    check("rerr_set", range_err, 1);
    check("rerr_valid", out_valid, 0);
    check("rerr_busy", busy, 0);
    repeat (3) tick();
    check("rerr_sticky", range_err, 1);
    enqueue(0);
    expect_entry(1, 3, -1, 0, 0);
    expect_entry(2, -8, 7, 1, 0);
    check("rerr_sticky2", range_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
